// File: rtl/state_sampler.sv
// state_sampler: draws a next POMDP state from a transition row by
// scanning cumulative probabilities against a latched random word.
module state_sampler #(
    parameter int NUM_STATES  = 4,
    parameter int NUM_ACTIONS = 3,
    parameter int PROB_W      = 16,
    localparam int SW = (NUM_STATES > 1) ? $clog2(NUM_STATES) : 1,
    localparam int AW = (NUM_ACTIONS > 1) ? $clog2(NUM_ACTIONS) : 1
) (
    input  logic                                          clk,
    input  logic                                          rst,
    input  logic                                          en,
    input  logic [SW-1:0]                                 cur_state,
    input  logic [AW-1:0]                                 action,
    input  logic [PROB_W-1:0]                             random,
    input  logic [NUM_ACTIONS*NUM_STATES*NUM_STATES*PROB_W-1:0] trans,
    output logic [SW-1:0]                                 new_state,
    output logic                                          valid,
    output logic                                          busy,
    output logic                                          fallback
);

    localparam int unsigned NS = NUM_STATES;
    localparam int unsigned NE = NUM_ACTIONS * NUM_STATES * NUM_STATES;
    localparam int EW = (NE > 1) ? $clog2(NE) : 1;
    localparam int XW = PROB_W + SW;
    localparam logic [SW-1:0] LAST = SW'(NUM_STATES - 1);

    typedef enum logic {
        IDLE,
        SCAN
    } state_t;

    state_t             state_q, state_d;
    logic [SW-1:0]      cur_q, cur_d;
    logic [AW-1:0]      act_q, act_d;
    logic [PROB_W-1:0]  rnd_q, rnd_d;
    logic [SW-1:0]      idx_q, idx_d;
    logic [XW-1:0]      acc_q, acc_d;
    logic [SW-1:0]      ns_d;
    logic               fb_d;
    logic               valid_d;

    logic [PROB_W-1:0]  tbl [NE];
    logic [31:0]        ent;
    logic [EW-1:0]      ent_w;
    logic [PROB_W-1:0]  prob;
    logic [XW-1:0]      sum;

    for (genvar i = 0; i < NE; i++) begin : g_tbl
        assign tbl[i] = trans[i*PROB_W +: PROB_W];
    end

    // Entry lookup wraps out-of-range operands onto the flattened table.
    always_comb begin
        ent   = (((32'(act_q) * NS) + 32'(cur_q)) * NS + 32'(idx_q)) % NE;
        ent_w = EW'(ent);
        prob  = tbl[ent_w];
        sum   = acc_q + XW'(prob);
    end

    // Next-state and next-output logic; a new request overrides the scan
    // but never discards a result completing in the same cycle.
    always_comb begin
        state_d = state_q;
        cur_d   = cur_q;
        act_d   = act_q;
        rnd_d   = rnd_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        ns_d    = new_state;
        fb_d    = fallback;
        valid_d = 1'b0;
        if (state_q == SCAN) begin
            if (XW'(rnd_q) < sum) begin
                ns_d    = idx_q;
                fb_d    = 1'b0;
                valid_d = 1'b1;
                state_d = IDLE;
            end else if (idx_q == LAST) begin
                ns_d    = LAST;
                fb_d    = 1'b1;
                valid_d = 1'b1;
                state_d = IDLE;
            end else begin
                acc_d = sum;
                idx_d = idx_q + 1'b1;
            end
        end
        if (en) begin
            cur_d   = cur_state;
            act_d   = action;
            rnd_d   = random;
            idx_d   = '0;
            acc_d   = '0;
            state_d = SCAN;
        end
    end

    // State and result registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            cur_q     <= '0;
            act_q     <= '0;
            rnd_q     <= '0;
            idx_q     <= '0;
            acc_q     <= '0;
            new_state <= '0;
            fallback  <= 1'b0;
            valid     <= 1'b0;
        end else begin
            state_q   <= state_d;
            cur_q     <= cur_d;
            act_q     <= act_d;
            rnd_q     <= rnd_d;
            idx_q     <= idx_d;
            acc_q     <= acc_d;
            new_state <= ns_d;
            fallback  <= fb_d;
            valid     <= valid_d;
        end
    end

    assign busy = (state_q == SCAN);

endmodule

// File: tb/tb_state_sampler.sv
// tb_state_sampler: directed and randomized checks of state_sampler
// against a cumulative-probability reference model.
module tb_state_sampler;

    localparam int NS = 4;
    localparam int NA = 3;
    localparam int PW = 16;
    localparam int NE = NA * NS * NS;

    logic             clk = 1'b0;
    logic             rst;
    logic             en;
    logic [1:0]       cur_state;
    logic [1:0]       action;
    logic [PW-1:0]    random;
    logic [NE*PW-1:0] trans;
    logic [1:0]       new_state;
    logic             valid;
    logic             busy;
    logic             fallback;

    int checks = 0;
    int errors = 0;
    int flat [NE];

    state_sampler #(
        .NUM_STATES (NS),
        .NUM_ACTIONS(NA),
        .PROB_W     (PW)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .cur_state(cur_state),
        .action   (action),
        .random   (random),
        .trans    (trans),
        .new_state(new_state),
        .valid    (valid),
        .busy     (busy),
        .fallback (fallback)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic pack_table;
        for (int e = 0; e < NE; e++)
            trans[e*PW +: PW] = PW'(flat[e]);
    endtask

    task automatic set_row(input int a, input int s, input int p0,
                           input int p1, input int p2, input int p3);
        flat[(a*NS+s)*NS+0] = p0;
        flat[(a*NS+s)*NS+1] = p1;
        flat[(a*NS+s)*NS+2] = p2;
        flat[(a*NS+s)*NS+3] = p3;
        pack_table();
    endtask

    // First index whose running total exceeds r; else last state as fallback.
    function automatic int model(input int a, input int s, input int r,
                                 output int fb);
        int acc;
        acc = 0;
        for (int k = 0; k < NS; k++) begin
            acc += flat[((a*NS+s)*NS+k) % NE];
            if (r < acc) begin
                fb = 0;
                return k;
            end
        end
        fb = 1;
        return NS - 1;
    endfunction

    task automatic do_request(input int a, input int s, input int r,
                              output int ns, output int fb,
                              output int lat, output int bcnt,
                              output bit to);
        en = 1'b1;
        action = 2'(a);
        cur_state = 2'(s);
        random = PW'(r);
        tick();
        en = 1'b0;
        action = 2'($urandom);
        cur_state = 2'($urandom);
        random = PW'($urandom);
        lat = 1;
        bcnt = 0;
        to = 1'b0;
        while (!valid && lat < 20) begin
            if (busy) bcnt++;
            tick();
            lat++;
        end
        if (!valid) to = 1'b1;
        ns = int'(new_state);
        fb = int'(fallback);
    endtask

    task automatic test_reset;
        rst = 1'b1;
        en = 1'b1;
        tick();
        tick();
        checks++;
        if (new_state !== 2'd0) begin
            errors++;
            $display("FAIL rst_ns got %0d exp 0", new_state);
        end
        checks++;
        if (valid !== 1'b0) begin
            errors++;
            $display("FAIL rst_valid got %0b exp 0", valid);
        end
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL rst_busy got %0b exp 0", busy);
        end
        checks++;
        if (fallback !== 1'b0) begin
            errors++;
            $display("FAIL rst_fb got %0b exp 0", fallback);
        end
        en = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_directed;
        int ns, fb, lat, bc;
        bit to;
        set_row(2, 1, 'h4000, 'h4000, 'h4000, 'h4000);
        do_request(2, 1, 'h3FFF, ns, fb, lat, bc, to);
        checks++;
        if (to || lat != 2 || ns != 0 || fb != 0) begin
            errors++;
            $display("FAIL first_hit got lat=%0d ns=%0d fb=%0d exp 2/0/0",
                     lat, ns, fb);
        end
        tick();
        checks++;
        if (valid !== 1'b0 || new_state !== 2'd0) begin
            errors++;
            $display("FAIL hold got v=%0b ns=%0d exp 0/0", valid, new_state);
        end
        do_request(2, 1, 'hC000, ns, fb, lat, bc, to);
        checks++;
        if (to || lat != 5 || ns != 3 || fb != 0) begin
            errors++;
            $display("FAIL last_hit got lat=%0d ns=%0d fb=%0d exp 5/3/0",
                     lat, ns, fb);
        end
        checks++;
        if (bc != 4) begin
            errors++;
            $display("FAIL busy_len got %0d exp 4", bc);
        end
        set_row(2, 1, 'h1000, 0, 0, 0);
        do_request(2, 1, 'h8000, ns, fb, lat, bc, to);
        checks++;
        if (to || lat != 5 || ns != 3 || fb != 1) begin
            errors++;
            $display("FAIL fallback got lat=%0d ns=%0d fb=%0d exp 5/3/1",
                     lat, ns, fb);
        end
        tick();
        checks++;
        if (valid !== 1'b0 || fallback !== 1'b1) begin
            errors++;
            $display("FAIL fb_hold got v=%0b fb=%0b exp 0/1", valid, fallback);
        end
        set_row(2, 1, 0, 'hFFFF, 0, 0);
        do_request(2, 1, 0, ns, fb, lat, bc, to);
        checks++;
        if (to || lat != 3 || ns != 1 || fb != 0) begin
            errors++;
            $display("FAIL zero_skip got lat=%0d ns=%0d fb=%0d exp 3/1/0",
                     lat, ns, fb);
        end
        tick();
    endtask

    task automatic test_back_to_back;
        int stray;
        set_row(0, 0, 'hFFFF, 0, 0, 0);
        en = 1'b1; action = 2'd0; cur_state = 2'd0; random = 16'hFFFF;
        tick();
        en = 1'b0;
        stray = int'(valid);
        tick();
        stray += int'(valid);
        en = 1'b1; action = 2'd0; cur_state = 2'd0; random = 16'h0000;
        tick();
        en = 1'b0;
        stray += int'(valid);
        tick();
        checks++;
        if (valid !== 1'b1 || new_state !== 2'd0 || fallback !== 1'b0) begin
            errors++;
            $display("FAIL b2b_result got v=%0b ns=%0d fb=%0b exp 1/0/0",
                     valid, new_state, fallback);
        end
        for (int i = 0; i < 5; i++) begin
            tick();
            stray += int'(valid);
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL b2b_stray got %0d extra valids exp 0", stray);
        end
    endtask

    task automatic test_en_on_complete;
        set_row(0, 0, 'hFFFF, 0, 0, 0);
        set_row(1, 0, 0, 'hFFFF, 0, 0);
        en = 1'b1; action = 2'd0; cur_state = 2'd0; random = 16'h0000;
        tick();
        en = 1'b1; action = 2'd1; cur_state = 2'd0; random = 16'h0000;
        tick();
        en = 1'b0;
        checks++;
        if (valid !== 1'b1 || new_state !== 2'd0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL overlap_keep got v=%0b ns=%0d busy=%0b exp 1/0/1",
                     valid, new_state, busy);
        end
        tick();
        tick();
        checks++;
        if (valid !== 1'b1 || new_state !== 2'd1) begin
            errors++;
            $display("FAIL overlap_next got v=%0b ns=%0d exp 1/1",
                     valid, new_state);
        end
        tick();
    endtask

    task automatic test_rst_mid_scan;
        int stray;
        set_row(2, 1, 'h1000, 0, 0, 0);
        en = 1'b1; action = 2'd2; cur_state = 2'd1; random = 16'h8000;
        tick();
        en = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (valid !== 1'b0 || busy !== 1'b0 || new_state !== 2'd0 ||
            fallback !== 1'b0) begin
            errors++;
            $display("FAIL rst_mid got v=%0b b=%0b ns=%0d fb=%0b exp 0/0/0/0",
                     valid, busy, new_state, fallback);
        end
        stray = 0;
        for (int i = 0; i < 6; i++) begin
            tick();
            stray += int'(valid);
        end
        checks++;
        if (stray != 0) begin
            errors++;
            $display("FAIL rst_stray got %0d valids exp 0", stray);
        end
    endtask

    task automatic test_random;
        int ns, fb, lat, bc, a, s, r, ek, efb;
        bit to;
        for (int it = 0; it < 40; it++) begin
            for (int e = 0; e < NE; e++)
                flat[e] = ($urandom_range(0, 3) == 0) ? 0 :
                          int'($urandom_range(0, 'h5000));
            pack_table();
            a = int'($urandom_range(0, 3));
            s = int'($urandom_range(0, 3));
            r = int'($urandom_range(0, 'hFFFF));
            ek = model(a, s, r, efb);
            do_request(a, s, r, ns, fb, lat, bc, to);
            checks++;
            if (to || ns != ek || fb != efb || lat != ek + 2 || bc != ek + 1)
            begin
                errors++;
                $display("FAIL rand%0d got ns=%0d fb=%0d lat=%0d busy=%0d exp %0d/%0d/%0d/%0d",
                         it, ns, fb, lat, bc, ek, efb, ek + 2, ek + 1);
            end
            tick();
            checks++;
            if (valid !== 1'b0 || int'(new_state) != ek) begin
                errors++;
                $display("FAIL rand_hold%0d got v=%0b ns=%0d exp 0/%0d",
                         it, valid, new_state, ek);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        en = 1'b0;
        cur_state = '0;
        action = '0;
        random = '0;
        for (int e = 0; e < NE; e++) flat[e] = 0;
        pack_table();
        tick();
        test_reset();
        test_directed();
        test_back_to_back();
        test_en_on_complete();
        test_rst_mid_scan();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
